// File: rtl/stereo_pkg.sv
// Shared types and defaults for the stereo SSD disparity search.
// The second-best tracking is compiled in only when SSD_CONFIDENCE_EN is defined.
package stereo_pkg;

   localparam int WIN_DEF         = 6;
   localparam int MAX_DISP_DEF    = 16;
   localparam int MAC_LATENCY_DEF = 12;
   localparam int IMG_W_DEF       = 320;
   // Second-best minus best must reach this for a confident match.
   localparam int CONF_MARGIN     = 256;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      FEED,
      DRAIN,
      COMPARE,
      DONE
   } seq_state_e;

   // Worst-case SSD over a window of 8-bit pixels, plus one headroom bit.
   function automatic int acc_width(input int win);
      return $clog2(255 * 255 * win) + 1;
   endfunction

endpackage

// File: rtl/ssd_disparity_sequencer_min_tracker.sv
// ssd_min_tracker: running minimum SSD cost and its disparity; res_* show post-sample values.
// SSD_CONFIDENCE_EN adds a second-best register driving the confidence flag.
module ssd_min_tracker
   import stereo_pkg::*;
#(
   parameter int ACC_W  = 20,
   parameter int DISP_W = 4
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              clear,
   input  logic              sample,
   input  logic [ACC_W-1:0]  acc,
   input  logic [DISP_W-1:0] disp,
   output logic [DISP_W-1:0] res_disp,
   output logic [ACC_W-1:0]  res_cost,
   output logic              res_conf
);

   logic [ACC_W-1:0]  best_cost_q;
   logic [DISP_W-1:0] best_disp_q;
   logic              new_best;

   assign new_best = sample && (acc < best_cost_q);

   always_comb begin
      res_cost = best_cost_q;
      res_disp = best_disp_q;
      if (new_best) begin
         res_cost = acc;
         res_disp = disp;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         best_cost_q <= '1;
         best_disp_q <= '0;
      end else if (clear) begin
         best_cost_q <= '1;
         best_disp_q <= '0;
      end else begin
         best_cost_q <= res_cost;
         best_disp_q <= res_disp;
      end
   end

`ifdef SSD_CONFIDENCE_EN
   logic [ACC_W-1:0] second_q;
   logic [ACC_W-1:0] second_nxt;
   logic             seen_q;
   logic             multi_q;
   logic             multi_nxt;

   always_comb begin
      second_nxt = second_q;
      if (new_best)
         second_nxt = best_cost_q;
      else if (sample && (acc < second_q))
         second_nxt = acc;
   end

   assign multi_nxt = multi_q || (sample && seen_q);
   // A single evaluated candidate has nothing to compete with.
   assign res_conf  = !multi_nxt || ((second_nxt - res_cost) >= ACC_W'(CONF_MARGIN));

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         second_q <= '1;
         seen_q   <= 1'b0;
         multi_q  <= 1'b0;
      end else if (clear) begin
         second_q <= '1;
         seen_q   <= 1'b0;
         multi_q  <= 1'b0;
      end else begin
         second_q <= second_nxt;
         seen_q   <= seen_q || sample;
         multi_q  <= multi_nxt;
      end
   end
`else
   assign res_conf = 1'b1;
`endif

endmodule

// File: rtl/ssd_disparity_sequencer.sv
// Drives line-buffer reads and one MAC engine to find the min-SSD disparity of a window.
// SSD_CONFIDENCE_EN selects the second-best based confidence flag in ssd_min_tracker.
//
// state   | meaning
// IDLE    | waiting for an in-range start
// CHECK   | skip d if x < d, else clear the MAC
// FEED    | WIN column reads, pixels forwarded to the MAC one cycle later
// DRAIN   | MAC_LATENCY+1 cycles for the accumulator to settle
// COMPARE | sample accumulator into the min tracker
// DONE    | result strobe
module ssd_disparity_sequencer
   import stereo_pkg::*;
#(
   parameter int WIN         = WIN_DEF,
   parameter int MAX_DISP    = MAX_DISP_DEF,
   parameter int MAC_LATENCY = MAC_LATENCY_DEF,
   parameter int IMG_W       = IMG_W_DEF,
   localparam int COL_W      = $clog2(IMG_W),
   localparam int DISP_W     = $clog2(MAX_DISP),
   localparam int ACC_W      = acc_width(WIN)
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start_in,
   input  logic [COL_W-1:0]  x_in,
   output logic              busy_out,
   output logic [COL_W-1:0]  left_col_out,
   output logic [COL_W-1:0]  right_col_out,
   input  logic [7:0]        left_pix_in,
   input  logic [7:0]        right_pix_in,
   output logic              mac_rst_out,
   output logic              mac_valid_out,
   output logic [7:0]        mac_left_out,
   output logic [7:0]        mac_right_out,
   input  logic [ACC_W-1:0]  mac_acc_in,
   output logic              done_out,
   output logic [DISP_W-1:0] disp_out,
   output logic [ACC_W-1:0]  cost_out,
   output logic              confident_out
);

   localparam int TMR_MAX = (WIN - 1 > MAC_LATENCY) ? WIN - 1 : MAC_LATENCY;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   seq_state_e        state_q, state_nxt;
   logic [COL_W-1:0]  x_q;
   logic [DISP_W-1:0] d_q;
   logic [TMR_W-1:0]  tmr_q;
   logic              accept, skip, last_d, tmr_tc, sample;
   logic [DISP_W-1:0] res_disp;
   logic [ACC_W-1:0]  res_cost;
   logic              res_conf;

   assign accept = start_in && (x_in <= COL_W'(IMG_W - WIN));
   assign skip   = x_q < COL_W'(d_q);
   assign last_d = d_q == DISP_W'(MAX_DISP - 1);
   assign tmr_tc = tmr_q == '0;

   assign mac_left_out  = left_pix_in;
   assign mac_right_out = right_pix_in;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt   = state_q;
      busy_out    = 1'b1;
      mac_rst_out = 1'b0;
      done_out    = 1'b0;
      sample      = 1'b0;
      case (state_q)
         IDLE: begin
            busy_out = 1'b0;
            if (accept) state_nxt = CHECK;
         end
         CHECK: begin
            if (skip) begin
               if (last_d) state_nxt = DONE;
            end else begin
               mac_rst_out = 1'b1;
               state_nxt   = FEED;
            end
         end
         FEED:    if (tmr_tc) state_nxt = DRAIN;
         DRAIN:   if (tmr_tc) state_nxt = COMPARE;
         COMPARE: begin
            sample    = 1'b1;
            state_nxt = last_d ? DONE : CHECK;
         end
         DONE: begin
            done_out  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         x_q           <= '0;
         d_q           <= '0;
         tmr_q         <= '0;
         left_col_out  <= '0;
         right_col_out <= '0;
         mac_valid_out <= 1'b0;
         disp_out      <= '0;
         cost_out      <= '0;
         confident_out <= 1'b0;
      end else begin
         // Line buffers return data one cycle after the address.
         mac_valid_out <= (state_q == FEED);
         case (state_q)
            IDLE: begin
               if (accept) begin
                  x_q <= x_in;
                  d_q <= '0;
               end
            end
            CHECK: begin
               if (!skip) begin
                  left_col_out  <= x_q;
                  right_col_out <= x_q - COL_W'(d_q);
                  tmr_q         <= TMR_W'(WIN - 1);
               end else if (!last_d) begin
                  d_q <= d_q + DISP_W'(1);
               end
            end
            FEED: begin
               left_col_out  <= left_col_out + COL_W'(1);
               right_col_out <= right_col_out + COL_W'(1);
               tmr_q         <= tmr_tc ? TMR_W'(MAC_LATENCY) : tmr_q - TMR_W'(1);
            end
            DRAIN: begin
               if (!tmr_tc) tmr_q <= tmr_q - TMR_W'(1);
            end
            COMPARE: begin
               if (!last_d) d_q <= d_q + DISP_W'(1);
            end
            default: ;
         endcase
         // Result registers load on the edge into DONE so they appear with done_out.
         if (state_nxt == DONE) begin
            disp_out      <= res_disp;
            cost_out      <= res_cost;
            confident_out <= res_conf;
         end
      end
   end

   ssd_min_tracker #(
      .ACC_W  (ACC_W),
      .DISP_W (DISP_W)
   ) u_min_tracker (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .clear    ((state_q == IDLE) && accept),
      .sample   (sample),
      .acc      (mac_acc_in),
      .disp     (d_q),
      .res_disp (res_disp),
      .res_cost (res_cost),
      .res_conf (res_conf)
   );

endmodule

// File: tb/tb_ssd_disparity_sequencer.sv
// Directed bench for ssd_disparity_sequencer at MAX_DISP=4 with behavioural line buffers and MAC.
// Edge numbers count the start-sampling edge as edge 1.
module tb_ssd_disparity_sequencer;

   localparam int COL_W = 9;
   localparam int DISP_W = 2;
   localparam int ACC_W = 20;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start_in = 1'b0;
   logic [COL_W-1:0]  x_in = '0;
   logic              busy_out;
   logic [COL_W-1:0]  left_col_out, right_col_out;
   logic [7:0]        left_pix, right_pix;
   logic              mac_rst_out, mac_valid_out;
   logic [7:0]        mac_left_out, mac_right_out;
   logic [ACC_W-1:0]  mac_acc_in;
   logic              done_out;
   logic [DISP_W-1:0] disp_out;
   logic [ACC_W-1:0]  cost_out;
   logic              confident_out;

   int n_cmp = 0;
   int n_fail = 0;

   logic [7:0]       left_row  [0:511];
   logic [7:0]       right_row [0:511];
   logic [ACC_W-1:0] acc_model = '0;
   logic             forced_mode = 1'b0;
   logic [ACC_W-1:0] forced_cost [0:3];

   always #5 clk = ~clk;

   ssd_disparity_sequencer #(.MAX_DISP(4)) dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .start_in      (start_in),
      .x_in          (x_in),
      .busy_out      (busy_out),
      .left_col_out  (left_col_out),
      .right_col_out (right_col_out),
      .left_pix_in   (left_pix),
      .right_pix_in  (right_pix),
      .mac_rst_out   (mac_rst_out),
      .mac_valid_out (mac_valid_out),
      .mac_left_out  (mac_left_out),
      .mac_right_out (mac_right_out),
      .mac_acc_in    (mac_acc_in),
      .done_out      (done_out),
      .disp_out      (disp_out),
      .cost_out      (cost_out),
      .confident_out (confident_out)
   );

   // Registered line-buffer reads and a zero-latency MAC.
   always @(posedge clk) begin
      left_pix  <= left_row[left_col_out];
      right_pix <= right_row[right_col_out];
      if (mac_rst_out)
         acc_model <= '0;
      else if (mac_valid_out)
         acc_model <= acc_model + ACC_W'((int'(mac_left_out) - int'(mac_right_out)) *
                                         (int'(mac_left_out) - int'(mac_right_out)));
   end

   // In forced mode the cost depends only on the candidate, left_col - right_col = d.
   logic [COL_W-1:0] d_now;
   assign d_now = left_col_out - right_col_out;
   assign mac_acc_in = forced_mode ? forced_cost[d_now[1:0]] : acc_model;

   typedef struct {
      int x;
      int pat;
      int edges;
      int disp;
      int cost;
      int n_eval;
      int conf_c;
   } vec_t;

   vec_t vecs [0:7];

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_pattern(input int pat);
      forced_mode = 1'b0;
      for (int c = 0; c < 512; c++) begin
         left_row[c]  = 8'd100;
         right_row[c] = 8'd90;
      end
      if (pat == 1) begin
         for (int c = 0; c < 512; c++) left_row[c] = 8'((c * 11) & 255);
         for (int c = 0; c < 510; c++) right_row[c] = left_row[c + 2];
      end else if (pat == 2) begin
         forced_mode = 1'b1;
         forced_cost[0] = 20'd600;  forced_cost[1] = 20'd650;
         forced_cost[2] = 20'd900;  forced_cost[3] = 20'd1200;
      end else if (pat == 3) begin
         forced_mode = 1'b1;
         forced_cost[0] = 20'd0;    forced_cost[1] = 20'd600;
         forced_cost[2] = 20'd700;  forced_cost[3] = 20'd800;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int cnt, done_at, n_valid, n_rise, n_rst, bad_busy, bad_col, extra_done, exp_conf;
      logic prev_valid;
      string tag;
      tag = $sformatf("v%0d", idx);
      set_pattern(v.pat);
      @(negedge clk);
      start_in = 1'b1;
      x_in = COL_W'(v.x);
      @(posedge clk);
      cnt = 1;
      #1 start_in = 1'b0;
      done_at = 0; n_valid = 0; n_rise = 0; n_rst = 0; bad_busy = 0; bad_col = 0;
      prev_valid = 1'b0;
      while (done_at == 0 && cnt < 300) begin
         @(negedge clk);
         // A start while busy must be ignored.
         if (cnt == 10) begin
            start_in = 1'b1;
            x_in = COL_W'(3);
         end else begin
            start_in = 1'b0;
         end
         if (!busy_out) bad_busy++;
         if (right_col_out > left_col_out) bad_col++;
         if (mac_valid_out) n_valid++;
         if (mac_valid_out && !prev_valid) n_rise++;
         prev_valid = mac_valid_out;
         if (mac_rst_out) n_rst++;
         if (done_out) done_at = cnt;
         else begin
            @(posedge clk);
            cnt++;
         end
      end
      start_in = 1'b0;
      check({tag, "_done_edge"}, done_at, v.edges);
      check({tag, "_disp"}, disp_out, v.disp);
      check({tag, "_cost"}, cost_out, v.cost);
`ifdef SSD_CONFIDENCE_EN
      exp_conf = v.conf_c;
`else
      exp_conf = 1;
`endif
      check({tag, "_confident"}, confident_out, exp_conf);
      check({tag, "_valid_cycles"}, n_valid, 6 * v.n_eval);
      check({tag, "_valid_bursts"}, n_rise, v.n_eval);
      check({tag, "_mac_rst"}, n_rst, v.n_eval);
      check({tag, "_busy_hold"}, bad_busy, 0);
      check({tag, "_right_col_order"}, bad_col, 0);
      @(negedge clk);
      check({tag, "_done_pulse"}, {done_out, busy_out}, 0);
      extra_done = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done_out || busy_out) extra_done++;
      end
      check({tag, "_no_extra_done"}, extra_done, 0);
   endtask

   initial begin
      int cnt, late;
      vecs[0] = '{x: 10,  pat: 0, edges: 85, disp: 0, cost: 600, n_eval: 4, conf_c: 0};
      vecs[1] = '{x: 10,  pat: 1, edges: 85, disp: 2, cost: 0,   n_eval: 4, conf_c: 1};
      vecs[2] = '{x: 1,   pat: 0, edges: 45, disp: 0, cost: 600, n_eval: 2, conf_c: 0};
      vecs[3] = '{x: 10,  pat: 2, edges: 85, disp: 0, cost: 600, n_eval: 4, conf_c: 0};
      vecs[4] = '{x: 10,  pat: 3, edges: 85, disp: 0, cost: 0,   n_eval: 4, conf_c: 1};
      vecs[5] = '{x: 314, pat: 0, edges: 85, disp: 0, cost: 600, n_eval: 4, conf_c: 0};
      vecs[6] = '{x: 2,   pat: 0, edges: 65, disp: 0, cost: 600, n_eval: 3, conf_c: 0};
      vecs[7] = '{x: 0,   pat: 0, edges: 25, disp: 0, cost: 600, n_eval: 1, conf_c: 1};
      set_pattern(0);

      repeat (3) @(negedge clk);
      check("reset_outputs",
            {busy_out, done_out, mac_valid_out, mac_rst_out, left_col_out, right_col_out,
             disp_out, cost_out, confident_out}, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Out-of-range start column is rejected.
      @(negedge clk);
      start_in = 1'b1;
      x_in = COL_W'(315);
      @(negedge clk);
      start_in = 1'b0;
      check("reject_x315_busy", busy_out, 0);
      late = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done_out || busy_out) late++;
      end
      check("reject_x315_quiet", late, 0);

      // Reset during DRAIN of d=1 abandons the search.
      set_pattern(0);
      @(negedge clk);
      start_in = 1'b1;
      x_in = COL_W'(10);
      @(posedge clk);
      cnt = 1;
      #1 start_in = 1'b0;
      while (cnt < 30) begin
         @(posedge clk);
         cnt++;
      end
      @(negedge clk);
      check("drain_d1_busy", busy_out, 1);
      rst = 1'b1;
      #1;
      check("midrun_reset_outputs",
            {busy_out, done_out, mac_valid_out, mac_rst_out, left_col_out, right_col_out,
             disp_out, cost_out, confident_out}, 0);
      @(negedge clk);
      rst = 1'b0;
      late = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done_out || busy_out) late++;
      end
      check("midrun_reset_no_done", late, 0);

      run_vec(vecs[1], 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ssd_disparity_sequencer.md
Name: ssd_disparity_sequencer

Overview:
Sequences one mac_engine_8bit instance to compute a sum-of-squared-differences (SSD) cost for every candidate disparity of one left-image pixel window. It issues column addresses to the left/right line buffers and forwards the returned pixel pairs to the MAC. It clears the MAC between candidates, waits out the MAC pipeline, samples the accumulator, and reports the minimum-cost disparity. It sits between the stereo row controller (start/x) and the line buffers plus MAC engine.

Parameters:
WIN, 6, pixels per SSD window (pairs fed per disparity).
MAX_DISP, 16, number of candidate disparities, 0..MAX_DISP-1.
MAC_LATENCY, 12, cycles from the last MAC valid to a settled accumulator.
IMG_W, 320, image width in pixels.
COL_W, $clog2(IMG_W), column address width.
ACC_W, $clog2(255*255*WIN)+1, accumulator/cost width (20 at WIN=6).
CONF_MARGIN, 256, minimum second-best minus best cost for confidence (optional feature only).

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset; asynchronous, active-high
start_in  in  1  request evaluation of window at x_in
x_in  in  COL_W  left window start column
busy_out  out  1  high from accepted start through the done cycle
left_col_out  out  COL_W  left line-buffer read column
right_col_out  out  COL_W  right line-buffer read column
left_pix_in  in  8  left pixel, one cycle after address
right_pix_in  in  8  right pixel, one cycle after address
mac_rst_out  out  1  clear to MAC engine
mac_valid_out  out  1  pixel pair valid to MAC
mac_left_out  out  8  equals left_pix_in
mac_right_out  out  8  equals right_pix_in
mac_acc_in  in  ACC_W  MAC accumulator
done_out  out  1  one-cycle result strobe
disp_out  out  $clog2(MAX_DISP)  best disparity, held until next done
cost_out  out  ACC_W  best SSD cost, held
confident_out  out  1  confidence flag, held

Behaviour:
- Reset (async): state IDLE; busy_out, mac_rst_out, mac_valid_out, done_out, disp_out, cost_out, confident_out, column outputs all 0. Reset mid-search abandons the search with no done_out.
- IDLE: start_in sampled at rising edge. Accepted only if x_in <= IMG_W-WIN. On accept: latch x, set d=0, set best cost to all-ones, go to CHECK. Rejected or busy starts are ignored; no queueing.
- CHECK (1 cycle): if x < d, skip d. Otherwise assert mac_rst_out (Moore output of this state) and go to FEED.
- Skip handling: increment d and stay in CHECK, or go to DONE if d==MAX_DISP-1.
- FEED (WIN cycles, k=0..WIN-1): left_col_out=x+k, right_col_out=x-d+k. mac_valid_out is a one-cycle delayed copy of FEED, so it is high exactly WIN cycles, aligned with the returned pixels.
- DRAIN (MAC_LATENCY+1 cycles): counter from last FEED; mac_valid_out falls in the first DRAIN cycle.
- COMPARE (1 cycle): sample mac_acc_in. If it is strictly less than best, update best cost and disparity, so ties keep the lowest disparity. Then next CHECK, or DONE after d=MAX_DISP-1.
- DONE (1 cycle): done_out=1; disp_out/cost_out/confident_out updated in the same cycle; busy_out still 1. Then IDLE, where a start may be accepted the following edge.
- Timing: an evaluated disparity costs WIN+MAC_LATENCY+3 cycles; a skipped one costs 1. done_out rises at edge N_eval*(WIN+MAC_LATENCY+3)+N_skip+1 after the start edge.
- d=0 is always evaluated, so the result is always valid.

Optional Feature:
SSD_CONFIDENCE_EN:
- Defined: also track second-best cost, updated when acc < second and not a new best; a new best demotes the old best to second. confident_out=1 iff second-best minus best >= CONF_MARGIN, or if only one disparity was evaluated.
- Undefined: no second-best register; confident_out driven 1 after the first done (0 from reset).

Decomposition:
- Package stereo_pkg: WIN, ACC_W formula, the sequencer state enum (IDLE, CHECK, FEED, DRAIN, COMPARE, DONE).
- One sub-module, ssd_min_tracker: holds best/second-best cost and disparity, with clear, sample, and acc inputs. The SSD_CONFIDENCE_EN logic lives inside it.

Test Plan:
- WIN=6, MAC_LATENCY=12, MAX_DISP=4; left=100 and right=90 everywhere; start x=10 -> done at edge 85, disp 0, cost 600 (tie keeps lowest).
- Right row equals left shifted by 2 (right[c]=left[c+2]), random content, x=10 -> disp 2, cost 0; mac_valid_out high exactly 6 cycles per disparity, 4 times.
- x=1 -> d=2,3 skipped, done at edge 2*21+2+1=45; right_col_out never below 0.
- start asserted while busy, and start with x=315 (>IMG_W-WIN at IMG_W=320) -> ignored, no extra done, busy unchanged.
- rst_in pulsed during DRAIN of d=1 -> all outputs 0 immediately, no done_out; a new start then completes normally.
- SSD_CONFIDENCE_EN, CONF_MARGIN=256: costs 600/650/900/1200 -> confident_out 0; costs 0/600/... -> confident_out 1.
